// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Statistics counters exist only when MEM_ARB_STATS_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_LDR
    } arb_gnt_t;

    localparam int unsigned STAT_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Core, loader and memory-macro signals seen by the arbiter.
// slave = arbiter side, master = requesters and memory side.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_stats.sv
// Saturating grant/conflict counters for the arbiter.
// Instantiated only when MEM_ARB_STATS_EN is defined.
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_cpu,
    input  logic              inc_ldr,
    input  logic              inc_conflict,
    output logic [STAT_W-1:0] stat_cpu_grants,
    output logic [STAT_W-1:0] stat_ldr_grants,
    output logic [STAT_W-1:0] stat_conflicts
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cpu_grants <= '0;
            stat_ldr_grants <= '0;
            stat_conflicts  <= '0;
        end else begin
            if (inc_cpu)      stat_cpu_grants <= sat_inc(stat_cpu_grants);
            if (inc_ldr)      stat_ldr_grants <= sat_inc(stat_ldr_grants);
            if (inc_conflict) stat_conflicts  <= sat_inc(stat_conflicts);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between the core port and the loader/debug port.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict statistics outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter int unsigned LDR_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_arb_if.slave          bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cpu_grants,
    output logic [STAT_W-1:0] stat_ldr_grants,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned STV_W = $clog2(LDR_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(LDR_STARVE_MAX);

    arb_state_t        state_q,     state_nxt;
    arb_gnt_t          gnt_q,       gnt_nxt;
    logic [CNT_W-1:0]  cnt_q,       cnt_nxt;
    logic [STV_W-1:0]  starve_q,    starve_nxt;
    logic [ADDR_W-1:0] addr_q,      addr_nxt;
    logic [DATA_W-1:0] wdata_q,     wdata_nxt;
    logic              we_q,        we_nxt;
    logic              mem_we_q,    mem_we_nxt;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nxt;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_nxt;
    logic              cpu_ready_q, cpu_ready_nxt;
    logic              ldr_ready_q, ldr_ready_nxt;
    logic              ldr_wins_c;

    // Loader wins when alone, or when it has lost LDR_STARVE_MAX times in a row.
    assign ldr_wins_c = bus.ldr_req && (!bus.cpu_req || (starve_q == STV_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            cnt_q       <= '0;
            starve_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            gnt_q       <= gnt_nxt;
            cnt_q       <= cnt_nxt;
            starve_q    <= starve_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            we_q        <= we_nxt;
            mem_we_q    <= mem_we_nxt;
            cpu_rdata_q <= cpu_rdata_nxt;
            ldr_rdata_q <= ldr_rdata_nxt;
            cpu_ready_q <= cpu_ready_nxt;
            ldr_ready_q <= ldr_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        gnt_nxt       = gnt_q;
        cnt_nxt       = cnt_q;
        starve_nxt    = starve_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        we_nxt        = we_q;
        mem_we_nxt    = 1'b0;
        cpu_rdata_nxt = cpu_rdata_q;
        ldr_rdata_nxt = ldr_rdata_q;
        cpu_ready_nxt = 1'b0;
        ldr_ready_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.ldr_req) starve_nxt = '0;
                if (bus.cpu_req || bus.ldr_req) begin
                    if (ldr_wins_c) begin
                        gnt_nxt    = GNT_LDR;
                        starve_nxt = '0;
                        addr_nxt   = bus.ldr_addr;
                        wdata_nxt  = bus.ldr_wdata;
                        we_nxt     = bus.ldr_we;
                    end else begin
                        gnt_nxt    = GNT_CPU;
                        addr_nxt   = bus.cpu_addr;
                        wdata_nxt  = bus.cpu_wdata;
                        we_nxt     = bus.cpu_we;
                        if (bus.ldr_req && (starve_q != STV_MAX))
                            starve_nxt = STV_W'(starve_q + 1'b1);
                    end
                    // Strobe is registered here so it covers only the first ACCESS cycle.
                    mem_we_nxt = ldr_wins_c ? bus.ldr_we : bus.cpu_we;
                    cnt_nxt    = CNT_LOAD;
                    state_nxt  = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    if (gnt_q == GNT_LDR) begin
                        ldr_rdata_nxt = bus.mem_rdata;
                        ldr_ready_nxt = 1'b1;
                    end else begin
                        cpu_rdata_nxt = bus.mem_rdata;
                        cpu_ready_nxt = 1'b1;
                    end
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = CNT_W'(cnt_q - 1'b1);
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.ldr_ready = ldr_ready_q;

`ifdef MEM_ARB_STATS_EN
    logic grant_c;
    logic grant_cpu_c;
    logic grant_ldr_c;
    logic conflict_c;

    assign grant_c     = (state_q == IDLE) && (bus.cpu_req || bus.ldr_req);
    assign grant_cpu_c = grant_c && !ldr_wins_c;
    assign grant_ldr_c = grant_c && ldr_wins_c;
    assign conflict_c  = (state_q == IDLE) && bus.cpu_req && bus.ldr_req;

    mem_arb_stats u_stats (
        .clk             (clk),
        .reset           (reset),
        .inc_cpu         (grant_cpu_c),
        .inc_ldr         (grant_ldr_c),
        .inc_conflict    (conflict_c),
        .stat_cpu_grants (stat_cpu_grants),
        .stat_ldr_grants (stat_ldr_grants),
        .stat_conflicts  (stat_conflicts)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT 1 / STARVE 4 and WAIT 3 / STARVE 2)
// checked every cycle against a transaction-level model; MEM_ARB_STATS_EN adds stat checks.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int W_A = 1, S_A = 4, W_B = 3, S_B = 2;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } rq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [2];
    rq_t           drv   [2][2];
    logic [DW-1:0] mrd   [2];
    logic          mrd_fix [2];
    int            mode  [2][2];

    logic          o_cr [2], o_lr [2], o_mwe [2];
    logic [AW-1:0] o_ma [2];
    logic [DW-1:0] o_mwd [2], o_crd [2], o_lrd [2];

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.cpu_req   = drv[0][0].req;   assign ifb.cpu_req   = drv[1][0].req;
    assign ifa.cpu_we    = drv[0][0].we;    assign ifb.cpu_we    = drv[1][0].we;
    assign ifa.cpu_addr  = drv[0][0].addr;  assign ifb.cpu_addr  = drv[1][0].addr;
    assign ifa.cpu_wdata = drv[0][0].wdata; assign ifb.cpu_wdata = drv[1][0].wdata;
    assign ifa.ldr_req   = drv[0][1].req;   assign ifb.ldr_req   = drv[1][1].req;
    assign ifa.ldr_we    = drv[0][1].we;    assign ifb.ldr_we    = drv[1][1].we;
    assign ifa.ldr_addr  = drv[0][1].addr;  assign ifb.ldr_addr  = drv[1][1].addr;
    assign ifa.ldr_wdata = drv[0][1].wdata; assign ifb.ldr_wdata = drv[1][1].wdata;
    assign ifa.mem_rdata = mrd[0];          assign ifb.mem_rdata = mrd[1];

    assign o_cr[0]  = ifa.cpu_ready; assign o_cr[1]  = ifb.cpu_ready;
    assign o_lr[0]  = ifa.ldr_ready; assign o_lr[1]  = ifb.ldr_ready;
    assign o_mwe[0] = ifa.mem_we;    assign o_mwe[1] = ifb.mem_we;
    assign o_ma[0]  = ifa.mem_addr;  assign o_ma[1]  = ifb.mem_addr;
    assign o_mwd[0] = ifa.mem_wdata; assign o_mwd[1] = ifb.mem_wdata;
    assign o_crd[0] = ifa.cpu_rdata; assign o_crd[1] = ifb.cpu_rdata;
    assign o_lrd[0] = ifa.ldr_rdata; assign o_lrd[1] = ifb.ldr_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] st_cg [2], st_lg [2], st_cf [2];
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_A), .LDR_STARVE_MAX(S_A)) dut_a (
        .clk   (clk),
        .reset (rst_n[0]),
        .bus   (ifa)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_cpu_grants (st_cg[0]),
        .stat_ldr_grants (st_lg[0]),
        .stat_conflicts  (st_cf[0])
`endif
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_B), .LDR_STARVE_MAX(S_B)) dut_b (
        .clk   (clk),
        .reset (rst_n[1]),
        .bus   (ifb)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_cpu_grants (st_cg[1]),
        .stat_ldr_grants (st_lg[1]),
        .stat_conflicts  (st_cf[1])
`endif
    );

    // Transaction model: t counts cycles since grant (0 = no transaction in flight).
    int            mw [2], ms [2];
    int            m_t [2], m_st [2];
    logic          m_gl [2], m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2], m_rc [2], m_rl [2];
    int            m_ncg [2], m_nlg [2], m_ncf [2];

    int checks = 0;
    int errors = 0;
    int glog [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_t[d] = 0; m_st[d] = 0; m_gl[d] = 1'b0; m_we[d] = 1'b0;
        m_addr[d] = '0; m_wd[d] = '0; m_rc[d] = '0; m_rl[d] = '0;
        m_ncg[d] = 0; m_nlg[d] = 0; m_ncf[d] = 0;
    endtask

    task automatic model_step(input int d);
        logic c, l, take_l;
        rq_t  w;
        if (!rst_n[d]) begin
            model_reset(d);
            return;
        end
        if (m_t[d] == 0) begin
            c = drv[d][0].req;
            l = drv[d][1].req;
            if (c && l) m_ncf[d]++;
            if (c || l) begin
                take_l = l && (!c || m_st[d] == ms[d]);
                if (take_l || !l) m_st[d] = 0;
                else              m_st[d] = (m_st[d] + 1 > ms[d]) ? ms[d] : m_st[d] + 1;
                w = take_l ? drv[d][1] : drv[d][0];
                m_gl[d] = take_l; m_we[d] = w.we; m_addr[d] = w.addr; m_wd[d] = w.wdata;
                if (take_l) m_nlg[d]++; else m_ncg[d]++;
                m_t[d] = 1;
            end else begin
                m_st[d] = 0;
            end
        end else begin
            if (m_t[d] == mw[d]) begin
                if (m_gl[d]) m_rl[d] = mrd[d];
                else         m_rc[d] = mrd[d];
            end
            m_t[d] = (m_t[d] == mw[d] + 1) ? 0 : m_t[d] + 1;
        end
    endtask

    task automatic compare(input int d);
        string pf;
        pf = (d == 0) ? "a." : "b.";
        chk({pf, "cpu_ready"}, 32'(o_cr[d]),  32'(m_t[d] == mw[d] + 1 && !m_gl[d]));
        chk({pf, "ldr_ready"}, 32'(o_lr[d]),  32'(m_t[d] == mw[d] + 1 && m_gl[d]));
        chk({pf, "mem_we"},    32'(o_mwe[d]), 32'(m_t[d] == 1 && m_we[d]));
        chk({pf, "mem_addr"},  o_ma[d],  m_addr[d]);
        chk({pf, "mem_wdata"}, o_mwd[d], m_wd[d]);
        chk({pf, "cpu_rdata"}, o_crd[d], m_rc[d]);
        chk({pf, "ldr_rdata"}, o_lrd[d], m_rl[d]);
    endtask

    // Requester behaviour: drop on ready; mode 1 random, mode 2 always re-request.
    task automatic drive(input int d);
        logic rdy;
        for (int p = 0; p < 2; p++) begin
            rdy = (p == 0) ? o_cr[d] : o_lr[d];
            if (rdy) begin
                drv[d][p].req = 1'b0;
                if (d == 1) glog.push_back(p);
            end else if (mode[d][p] == 1) begin
                if (!drv[d][p].req) begin
                    if ($urandom_range(0, 2) == 0)
                        drv[d][p] = '{req: 1'b1, we: 1'($urandom_range(0, 1)),
                                      addr: $urandom(), wdata: $urandom()};
                end else if ($urandom_range(0, 3) == 0) begin
                    drv[d][p].we    = 1'($urandom_range(0, 1));
                    drv[d][p].addr  = $urandom();
                    drv[d][p].wdata = $urandom();
                end
            end else if (mode[d][p] == 2) begin
                drv[d][p].req = 1'b1;
            end
        end
        if (!mrd_fix[d]) mrd[d] = $urandom();
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare(0);
        compare(1);
        drive(0);
        drive(1);
    endtask

    initial begin
        int            exp_order [6];
        logic [DW-1:0] cap;

        exp_order = '{0, 0, 1, 0, 0, 1};
        mw[0] = W_A; ms[0] = S_A; mw[1] = W_B; ms[1] = S_B;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; mrd[d] = '0; mrd_fix[d] = 1'b0;
            model_reset(d);
            for (int p = 0; p < 2; p++) begin
                drv[d][p] = '0;
                mode[d][p] = 0;
            end
        end

        // Reset values
        repeat (2) cycle();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        cycle();

        // CPU read of 0x10 returning 0xDEADBEEF, WAIT_CYCLES=1
        mrd_fix[0] = 1'b1; mrd[0] = 32'hDEAD_BEEF;
        drv[0][0] = '{req: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0};
        cycle();
        chk("tp1.c1_mem_addr", o_ma[0], 32'h10);
        chk("tp1.c1_mem_we", 32'(o_mwe[0]), 32'd0);
        cycle();
        chk("tp1.c2_cpu_ready", 32'(o_cr[0]), 32'd1);
        chk("tp1.c2_cpu_rdata", o_crd[0], 32'hDEAD_BEEF);
        chk("tp1.c2_ldr_ready", 32'(o_lr[0]), 32'd0);
        chk("tp1.c2_mem_we", 32'(o_mwe[0]), 32'd0);
        cycle();
        chk("tp1.c3_cpu_ready", 32'(o_cr[0]), 32'd0);

        // Loader write 0x1234 to 0x40
        drv[0][1] = '{req: 1'b1, we: 1'b1, addr: 32'h40, wdata: 32'h1234};
        cycle();
        chk("tp2.c1_mem_we", 32'(o_mwe[0]), 32'd1);
        chk("tp2.c1_mem_addr", o_ma[0], 32'h40);
        chk("tp2.c1_mem_wdata", o_mwd[0], 32'h1234);
        chk("tp2.c1_ldr_ready", 32'(o_lr[0]), 32'd0);
        cycle();
        chk("tp2.c2_mem_we", 32'(o_mwe[0]), 32'd0);
        chk("tp2.c2_ldr_ready", 32'(o_lr[0]), 32'd1);
        cycle();
        mrd_fix[0] = 1'b0;

        // CPU read with WAIT_CYCLES=3: data sampled in cycle 3, ready in cycle 4
        drv[1][0] = '{req: 1'b1, we: 1'b0, addr: 32'h80, wdata: 32'h0};
        cycle();
        chk("tp3.c1_mem_we", 32'(o_mwe[1]), 32'd0);
        cycle();
        cycle();
        cap = mrd[1];
        chk("tp3.c3_mem_we", 32'(o_mwe[1]), 32'd0);
        chk("tp3.c3_cpu_ready", 32'(o_cr[1]), 32'd0);
        cycle();
        chk("tp3.c4_cpu_ready", 32'(o_cr[1]), 32'd1);
        chk("tp3.c4_cpu_rdata", o_crd[1], cap);
        cycle();

        // Starvation with LDR_STARVE_MAX=2, both requesting continuously
        glog.delete();
        mode[1][0] = 2; mode[1][1] = 2;
        drv[1][0] = '{req: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0};
        drv[1][1] = '{req: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0};
        for (int i = 0; i < 200 && glog.size() < 6; i++) cycle();
        chk("tp4.grant_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("tp4.grant%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF,
                32'(exp_order[i]));
        mode[1][0] = 0; mode[1][1] = 0;
        repeat (12) cycle();

        // Reset in first ACCESS cycle of a CPU write, then completion after release
        drv[0][0] = '{req: 1'b1, we: 1'b1, addr: 32'h24, wdata: 32'hCAFE_F00D};
        cycle();
        chk("tp5.pre_mem_we", 32'(o_mwe[0]), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        model_reset(0);
        #1;
        chk("tp5.rst_mem_we", 32'(o_mwe[0]), 32'd0);
        chk("tp5.rst_cpu_ready", 32'(o_cr[0]), 32'd0);
        compare(0);
        cycle();
        chk("tp5.held_cpu_ready", 32'(o_cr[0]), 32'd0);
        rst_n[0] = 1'b1;
        cycle();
        chk("tp5.c1_mem_we", 32'(o_mwe[0]), 32'd1);
        chk("tp5.c1_mem_wdata", o_mwd[0], 32'hCAFE_F00D);
        cycle();
        chk("tp5.c2_cpu_ready", 32'(o_cr[0]), 32'd1);
        cycle();

        // Random traffic on both instances with an asynchronous reset pulse midway
        for (int d = 0; d < 2; d++) begin
            mode[d][0] = 1; mode[d][1] = 1;
        end
        repeat (1500) cycle();
        #2;
        rst_n[1] = 1'b0;
        model_reset(1);
        #1;
        compare(1);
        cycle();
        rst_n[1] = 1'b1;
        repeat (1500) cycle();
        for (int d = 0; d < 2; d++) begin
            mode[d][0] = 0; mode[d][1] = 0;
        end
        repeat (20) cycle();
        chk("drain.cpu_req_a", 32'(drv[0][0].req), 32'd0);
        chk("drain.ldr_req_b", 32'(drv[1][1].req), 32'd0);

`ifdef MEM_ARB_STATS_EN
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stats%0d.cpu_grants", d), st_cg[d], 32'(m_ncg[d]));
            chk($sformatf("stats%0d.ldr_grants", d), st_lg[d], 32'(m_nlg[d]));
            chk($sformatf("stats%0d.conflicts", d),  st_cf[d], 32'(m_ncf[d]));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single unified instruction/data memory between the multicycle core's memory port and the program-loader/debug port. Each access is registered at grant, held for a parameterised number of memory wait cycles, and completed with a one-cycle `ready` pulse that returns read data. The core's control FSM holds its current state while `cpu_ready` is low. The arbiter sits between the core/loader and the memory macro.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 1: memory access cycles, ≥1; read data is valid at the end of the last one.
- `LDR_STARVE_MAX`, 4: consecutive lost arbitrations after which the loader wins; ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req` / `ldr_req`  in  1  access request; held until the matching `ready`.
- `cpu_we` / `ldr_we`  in  1  write enable for the request.
- `cpu_addr` / `ldr_addr`  in  ADDR_W  address.
- `cpu_wdata` / `ldr_wdata`  in  DATA_W  write data.
- `cpu_rdata` / `ldr_rdata`  out  DATA_W  read data; valid while `ready` is high.
- `cpu_ready` / `ldr_ready`  out  1  one-cycle completion pulse.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:** if any `req` is high, grant one requester, register its `addr`, `wdata` and `we`, load the wait counter with WAIT_CYCLES−1, then go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:**
  - CPU wins by default.
  - Loader wins if it is the only requester, or if both request and the starve counter equals LDR_STARVE_MAX.
  - The starve counter increments when the loader requests and loses. It clears when the loader is granted or `ldr_req` is low in IDLE. It saturates at LDR_STARVE_MAX.
- **ACCESS:**
  - `mem_addr` and `mem_wdata` are driven from the registered values.
  - `mem_we` is high only in the first ACCESS cycle, and only if the registered `we` is set.
  - The counter decrements each cycle. At 0, `mem_rdata` is captured into the granted requester's `rdata` register and the state moves to RESP.
- **RESP:** the granted requester's `ready` is 1 for exactly one cycle, then the state returns to IDLE unconditionally. RESP never arbitrates.
- Writes also update `rdata` with `mem_rdata` captured at the same point (don't-care for the requester).
- Outside ACCESS, `mem_we` = 0 and `mem_addr`/`mem_wdata` hold their last registered values.
- A requester changing its signals while not granted is permitted. Signals sampled at grant are authoritative.

## Timing
- Request high in IDLE cycle 0 → ACCESS cycles 1..WAIT_CYCLES → `ready` in cycle WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Reset values:
  - State IDLE; both `ready` = 0; `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, both `rdata` = 0.
  - Starve counter = 0.
- Reset asserted mid-ACCESS or RESP: outputs go to reset values immediately (asynchronous). An in-flight write strobe is cut and no `ready` is issued.
- After reset release, a still-pending request is served from IDLE normally.
- A requester must not raise a new request in the cycle its `ready` is high. It may re-request in the following cycle.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds three outputs, each 32 bits and saturating at all-ones, cleared by reset.
  - `stat_cpu_grants`: CPU grants.
  - `stat_ldr_grants`: loader grants.
  - `stat_conflicts`: IDLE cycles in which both requests were high.
- `MEM_ARB_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ACCESS, RESP};
  - grant enum `arb_gnt_t` {GNT_CPU, GNT_LDR};
  - the stat counter width constant.
- Sub-module `mem_arb_stats`: saturating counters, instantiated only under `MEM_ARB_STATS_EN`.

## Test plan
- WAIT_CYCLES=1, CPU read of 0x10, memory returns 0xDEADBEEF → `cpu_ready` in cycle 2 with `cpu_rdata`=0xDEADBEEF; `ldr_ready` stays 0; `mem_we` stays 0.
- Loader write of addr 0x40, data 0x1234 → `mem_we`=1 only in cycle 1 with `mem_addr`=0x40 and `mem_wdata`=0x1234; `ldr_ready` in cycle 2.
- WAIT_CYCLES=3, CPU read → `mem_we` low throughout; `cpu_ready` in cycle 4; data captured from `mem_rdata` in cycle 3.
- LDR_STARVE_MAX=2, both requesting continuously and the CPU re-requesting after each `ready` → grant order CPU, CPU, LDR, CPU, CPU, LDR.
- `reset` driven low in the first ACCESS cycle of a CPU write → `mem_we` falls immediately and no `cpu_ready` is issued; after release with `cpu_req` still high, the write completes with `cpu_ready` in cycle 2.
- With `MEM_ARB_STATS_EN`: 5 CPU and 3 loader accesses, 2 of them conflicting → stat outputs 5, 3, and the measured conflict-cycle count.
